// File: rtl/booth_arb_pkg.sv
// Shared types and sizes for the round-robin arbitrated shift-add multiplier.
package booth_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int OP_W   = 8;
  localparam int PROD_W = 16;
  localparam int STEPS  = 16;
  localparam int CTR_W  = 5;

  function automatic logic [PROD_W-1:0] sext_op(input logic [OP_W-1:0] v);
    return {{(PROD_W - OP_W){v[OP_W-1]}}, v};
  endfunction

endpackage

// File: rtl/booth_mul_core.sv
// Sequential shift-add multiplier: one partial-product step per cycle, 16 steps,
// single-cycle done pulse once the accumulator holds the final product.
module booth_mul_core
  import booth_arb_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic              done,
  output logic [PROD_W-1:0] product
);

  logic [PROD_W-1:0] mcand_reg;
  logic [PROD_W-1:0] mplier_reg;
  logic [PROD_W-1:0] acc_reg;
  logic [CTR_W-1:0]  ctr_reg;
  logic              active_reg;
  logic              done_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
      ctr_reg    <= '0;
      active_reg <= 1'b0;
      done_reg   <= 1'b0;
    end else if (start) begin
      mcand_reg  <= sext_op(a);
      mplier_reg <= sext_op(b);
      acc_reg    <= '0;
      ctr_reg    <= '0;
      active_reg <= 1'b1;
      done_reg   <= 1'b0;
    end else if (active_reg) begin
      // Sign-extended multiplier makes the 16-step unsigned sum equal the
      // signed product modulo 2^16.
      if (mplier_reg[ctr_reg[3:0]]) begin
        acc_reg <= acc_reg + mcand_reg;
      end
      mcand_reg <= mcand_reg << 1;
      ctr_reg   <= ctr_reg + 1'b1;
      if (ctr_reg == CTR_W'(STEPS - 1)) begin
        active_reg <= 1'b0;
        done_reg   <= 1'b1;
      end
    end else begin
      done_reg <= 1'b0;
    end
  end

  assign done    = done_reg;
  assign product = acc_reg;

endmodule

// File: rtl/booth_mul_arbiter.sv
// Round-robin arbiter granting NUM_REQ requesters access to one shared
// multiplier core, with a held response register and rsp_valid/rsp_ready handshake.
module booth_mul_arbiter
  import booth_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*OP_W-1:0] req_a,
  input  logic [NUM_REQ*OP_W-1:0] req_b,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [PROD_W-1:0]       rsp_p,
  output logic                    busy
);

  state_t              state_reg;
  state_t              state_next;
  logic [ID_W-1:0]     rr_ptr_reg;
  logic [ID_W-1:0]     gnt_id_reg;
  logic [PROD_W-1:0]   rsp_p_reg;
  logic [ID_W-1:0]     rsp_id_reg;

  logic [NUM_REQ-1:0]  grant;
  logic [ID_W-1:0]     gnt_idx;
  logic [ID_W-1:0]     idx;
  logic                accept;

  logic [OP_W-1:0]     a_arr [NUM_REQ];
  logic [OP_W-1:0]     b_arr [NUM_REQ];
  logic                core_done;
  logic [PROD_W-1:0]   core_product;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
    assign a_arr[gi] = req_a[gi*OP_W +: OP_W];
    assign b_arr[gi] = req_b[gi*OP_W +: OP_W];
  end

  // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    idx     = '0;
    accept  = 1'b0;
    if (state_reg == IDLE && !reset) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = ID_W'((int'(rr_ptr_reg) + k) % NUM_REQ);
        if (!accept && req_valid[idx]) begin
          accept     = 1'b1;
          gnt_idx    = idx;
          grant[idx] = 1'b1;
        end
      end
    end
  end

  assign req_ready = grant;

  booth_mul_core u_core (
    .clk     (clk),
    .reset   (reset),
    .start   (accept),
    .a       (a_arr[gnt_idx]),
    .b       (b_arr[gnt_idx]),
    .done    (core_done),
    .product (core_product)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    busy       = 1'b1;
    rsp_valid  = 1'b0;
    case (state_reg)
      IDLE: begin
        busy = 1'b0;
        if (accept) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (core_done) begin
          state_next = DONE;
        end
      end
      DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_reg <= '0;
      gnt_id_reg <= '0;
      rsp_p_reg  <= '0;
      rsp_id_reg <= '0;
    end else begin
      if (accept) begin
        rr_ptr_reg <= ID_W'((int'(gnt_idx) + 1) % NUM_REQ);
        gnt_id_reg <= gnt_idx;
      end
      // Response fields load only on RUN->DONE so they hold between operations.
      if (state_reg == RUN && core_done) begin
        rsp_p_reg  <= core_product;
        rsp_id_reg <= gnt_id_reg;
      end
    end
  end

  assign rsp_p  = rsp_p_reg;
  assign rsp_id = rsp_id_reg;

endmodule
